parity_generator_checker: RTL and testbench

Even-parity generator and checker for a DATA_W-bit word. It produces the even-parity bit of the input word combinationally. It flags an error when the word, taken as a received even-parity codeword, holds an odd number of ones. A registered, valid-qualified copy of both results and a sticky error flag feed downstream pipeline and status logic.

---
 rtl/parity_generator_checker.sv | 102 ++++++++++
 tb/tb_parity_generator_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_generator_checker.sv
// -----------------------------------------------------------------------------
// parity_generator_checker
//
// Even-parity generator and checker for a DATA_W-bit word.
//   * parity : even-parity bit that makes data+parity hold an even number of 1s
//   * error  : flag for data read as a received even-parity codeword with an
//              odd number of 1s
// Both are the XOR-reduction of data, so the two outputs always match. The
// block also keeps a valid-qualified registered copy of both, a one-cycle
// delayed valid, and a sticky error flag for status logic.
//
// Optional feature (compile-time macro PARITY_ERR_CNT_EN):
//   When defined, adds the err_count output. err_count is a saturating count
//   of registered parity errors, cleared by clr and by reset. When the macro
//   is undefined, the port and the counter are both absent.
//
// Parameters:
//   DATA_W : data word width, must be >= 2
//   CNT_W  : error counter width (only used with PARITY_ERR_CNT_EN)
// -----------------------------------------------------------------------------
module parity_generator_checker #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic              clr,
    output logic              parity,
    output logic              error,
    output logic              parity_q,
    output logic              error_q,
    output logic              valid_q,
    output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    // A word counts as an error only when valid qualifies it.
    logic capture_err;

    // Combinational parity/error: plain XOR-reduction. No clock or reset is
    // involved, and X bits on data propagate straight through.
    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        parity      = ^data;
        error       = ^data;
        capture_err = valid & (^data);
    end

    // Registered path: valid_q follows valid every cycle, and the
    // parity/error copies load only on valid words.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            valid_q <= valid;
            if (valid) begin
                parity_q <= parity;
                error_q  <= error;
            end
        end
    end

    // Sticky error flag: clr has priority, so an error that arrives in the
    // same cycle as clr is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_sticky <= 1'b0;
        end else if (capture_err) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // Saturating error counter: clr wins over increment. At all-ones the
    // counter stops and does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (capture_err && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    // Without the counter, CNT_W has no effect on the logic.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_parity_generator_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_generator_checker
//
// Directed testbench for parity_generator_checker (DATA_W = 4). It covers:
//   * the combinational sweep with no clock running
//   * all 16 data values
//   * reset values of the registered outputs
//   * the registered path, hold on valid=0, and sticky set/clear priority
//   * an asynchronous reset between edges, then restart after release
// With PARITY_ERR_CNT_EN it also checks the saturating counter at CNT_W = 2.
// -----------------------------------------------------------------------------
module tb_parity_generator_checker;

    localparam int DATA_W = 4;
`ifdef PARITY_ERR_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic              clk;
    logic              clk_en;
    logic              rst_n;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              clr;
    logic              parity;
    logic              error;
    logic              parity_q;
    logic              error_q;
    logic              valid_q;
    logic              err_sticky;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0]  err_count;
`endif

    int tests_run;
    int tests_failed;

    parity_generator_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .valid      (valid),
        .clr        (clr),
        .parity     (parity),
        .error      (error),
        .parity_q   (parity_q),
        .error_q    (error_q),
        .valid_q    (valid_q),
        .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    // Clock: 10 ns period. It stays low until clk_en is set, so the first
    // part of the run has no clock at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            clk = clk_en ? ~clk : 1'b0;
        end
    end

    // One comparison point. It is counted, and on a mismatch it reports the
    // tag with the observed and expected values.
    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Reference parity: counts ones bit by bit instead of using a reduction.
    function automatic logic ref_parity(input logic [DATA_W-1:0] d);
        int ones;
        ones = 0;
        for (int b = 0; b < DATA_W; b++) begin
            if (d[b]) ones++;
        end
        return (ones % 2) == 1;
    endfunction

    // Waits for the next rising edge, then 1 ns so outputs are sampled away
    // from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks all registered outputs in one call.
    task automatic check_regs(input string tag, input logic exp_pq,
                              input logic exp_eq, input logic exp_vq,
                              input logic exp_st);
        check({tag, ".parity_q"},   {7'd0, parity_q},   {7'd0, exp_pq});
        check({tag, ".error_q"},    {7'd0, error_q},    {7'd0, exp_eq});
        check({tag, ".valid_q"},    {7'd0, valid_q},    {7'd0, exp_vq});
        check({tag, ".err_sticky"}, {7'd0, err_sticky}, {7'd0, exp_st});
    endtask

    // Directed vectors for the combinational sweep: data, parity, error.
    logic [DATA_W-1:0] sweep_data [7];
    logic              sweep_par  [7];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clk_en       = 1'b0;
        rst_n        = 1'b0;
        data         = '0;
        valid        = 1'b0;
        clr          = 1'b0;

        sweep_data = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1111, 4'b1010, 4'b1011};
        sweep_par  = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};

        // Reset values, with no clock running.
        #2;
        check_regs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PARITY_ERR_CNT_EN
        check("reset.err_count", {6'd0, err_count}, 8'd0);
`endif

        // Combinational sweep, no clock, 10 ns per value.
        for (int i = 0; i < 7; i++) begin
            data = sweep_data[i];
            #10;
            check($sformatf("sweep[%b].parity", sweep_data[i]),
                  {7'd0, parity}, {7'd0, sweep_par[i]});
            check($sformatf("sweep[%b].error", sweep_data[i]),
                  {7'd0, error}, {7'd0, sweep_par[i]});
        end

        // All 16 data values against the bit-count model.
        for (int v = 0; v < 16; v++) begin
            data = DATA_W'(v);
            #1;
            check($sformatf("exh[%0d].parity", v), {7'd0, parity},
                  {7'd0, ref_parity(DATA_W'(v))});
            check($sformatf("exh[%0d].error", v), {7'd0, error},
                  {7'd0, ref_parity(DATA_W'(v))});
        end

        // Start the clock and release reset between edges.
        clk_en = 1'b1;
        data   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_regs("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 0111 (three ones) with valid: captured after one cycle and sets sticky.
        data  = 4'b0111;
        valid = 1'b1;
        step();
        check_regs("cap_0111", 1'b1, 1'b1, 1'b1, 1'b1);

        // 0110 with valid=0: parity_q/error_q hold, valid_q drops.
        data  = 4'b0110;
        valid = 1'b0;
        step();
        check_regs("hold_0110", 1'b1, 1'b1, 1'b0, 1'b1);

        // clr together with an erroring valid word: clear wins.
        clr   = 1'b1;
        data  = 4'b0001;
        valid = 1'b1;
        step();
        check_regs("clr_vs_err", 1'b1, 1'b1, 1'b1, 1'b0);

        // Clean word after the clear: sticky stays 0.
        clr  = 1'b0;
        data = 4'b0011;
        step();
        check_regs("clean_0011", 1'b0, 1'b0, 1'b1, 1'b0);

        // An erroring word with valid=0 must not set sticky.
        data  = 4'b1110;
        valid = 1'b0;
        step();
        check_regs("err_not_valid", 1'b0, 1'b0, 1'b0, 1'b0);

        // Build up error_q=1, then assert reset between edges.
        data  = 4'b1101;
        valid = 1'b1;
        step();
        check_regs("pre_async", 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("async_rst.parity_1101", {7'd0, parity}, 8'd1);
        data = 4'b1001;
        #1;
        check("async_rst.parity_1001", {7'd0, parity}, 8'd0);
        check("async_rst.error_1001", {7'd0, error}, 8'd0);

        // Reset held across a rising edge with valid high: state stays cleared.
        data = 4'b1000;
        step();
        check_regs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);

        // Release reset: the first valid word is captured normally.
        rst_n = 1'b1;
        data  = 4'b0100;
        step();
        check_regs("first_after_rst", 1'b1, 1'b1, 1'b1, 1'b1);

`ifdef PARITY_ERR_CNT_EN
        // Clear, then five valid error words: 1,2,3,3,3 (saturates at CNT_W=2).
        clr   = 1'b1;
        valid = 1'b0;
        step();
        check("cnt.cleared", {6'd0, err_count}, 8'd0);
        clr   = 1'b0;
        data  = 4'b1000;
        valid = 1'b1;
        step();
        check("cnt.1", {6'd0, err_count}, 8'd1);
        step();
        check("cnt.2", {6'd0, err_count}, 8'd2);
        step();
        check("cnt.3", {6'd0, err_count}, 8'd3);
        step();
        check("cnt.sat4", {6'd0, err_count}, 8'd3);
        step();
        check("cnt.sat5", {6'd0, err_count}, 8'd3);
        // clr beats the increment from a concurrent error word.
        clr = 1'b1;
        step();
        check("cnt.clr", {6'd0, err_count}, 8'd0);
        check("cnt.clr_sticky", {7'd0, err_sticky}, 8'd0);
        clr   = 1'b0;
        valid = 1'b0;
        step();
        check("cnt.idle_hold", {6'd0, err_count}, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global timeout: the directed sequence ends long before this bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
